tile_dma_packer: RTL
====================

Name: tile_dma_packer

Overview:
- Upstream feeder for the tile buffer bank.
- Accepts a one-pixel-per-clock DMA pixel stream with a valid/ready handshake.
- Packs PIX_PER_CLK pixels into one buffer word and drives the buffer write port (wr_en/wr_addr/wr_data) with sequential addresses.
- Sequences exactly one TILE_W x TILE_H tile per start command and reports completion and framing errors.

Parameters:
DATA_W, 8, bits per pixel
TILE_W, 32, tile width in pixels
TILE_H, 32, tile height in pixels
PIX_PER_CLK, 8, pixels per buffer word; must divide TILE_W*TILE_H
(derived) WORDS = TILE_W*TILE_H/PIX_PER_CLK; ADDR_W = $clog2(WORDS); LANE_W = max(1,$clog2(PIX_PER_CLK))

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin one tile transfer; honoured only in IDLE
busy  output  1  high while in FILL
done  output  1  one-cycle pulse when the final word is written
err_last  output  1  sticky framing error for the current/last tile
in_valid  input  1  pixel valid
in_ready  output  1  packer can accept a pixel
in_data  input  DATA_W  pixel value
in_last  input  1  marks the final pixel of the tile
wr_en  output  1  buffer write strobe
wr_addr  output  ADDR_W  buffer word address
wr_data  output  DATA_W*PIX_PER_CLK  packed word

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - busy=0, done=0, err_last=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - Lane and word counters are cleared.
  - A partial word is discarded; no write is issued for it.
- States IDLE and FILL. All outputs are registered, except in_ready and busy, which decode (state==FILL).
- IDLE:
  - in_ready=0.
  - start=1 -> FILL on the next edge; lane_cnt=0, word_cnt=0, err_last cleared.
- FILL:
  - in_ready=1 every cycle; there is no backpressure from the buffer.
  - start is ignored.
- Handshake: a pixel is accepted when in_valid && in_ready. There is no acceptance in any cycle where either is low; gaps of any length are allowed.
- Packing:
  - The accepted pixel goes into lane lane_cnt, at bits [lane*DATA_W +: DATA_W].
  - The first pixel of a word lands in lane 0, which is the LSBs.
  - lane_cnt increments and wraps from PIX_PER_CLK-1 to 0.
- Write issue:
  - Trigger: the cycle that accepts lane PIX_PER_CLK-1.
  - Next cycle: wr_en=1, wr_data = the complete word, wr_addr = word_cnt.
  - word_cnt then increments.
  - Write latency is 1 clock after the last pixel of the word. wr_en is high for exactly one cycle per word.
- Tile end:
  - The final pixel is the one accepted with word_cnt==WORDS-1 and lane==PIX_PER_CLK-1.
  - On that edge the state returns to IDLE, so in_ready=0 in the next cycle.
  - In that next cycle the final write (wr_addr=WORDS-1) and done=1 occur together.
- start during the done cycle:
  - The block is already in IDLE, so start is accepted.
  - The new tile begins at addr 0. The final write of the old tile still completes.
- Framing check:
  - err_last sets if in_last=1 on any accepted pixel other than the final one.
  - err_last also sets if in_last=0 on the final pixel.
  - The tile still terminates on pixel count only.
  - err_last is sticky until the next accepted start or reset.
- Back-to-back: consecutive tiles reuse addresses 0..WORDS-1. The write port has no read interaction.
- Width rules: wr_addr is exactly ADDR_W bits and never exceeds WORDS-1.

Test Plan:
- Reset, then start, then 1024 consecutive pixels (value = index mod 256, in_last on #1023):
  - 128 writes, addr 0..127.
  - Word 0 = 0x0706050403020100; word 127 = 0xFFFEFDFCFBFAF9F8.
  - done=1 in the same cycle as the addr-127 write; err_last=0; in_ready=0 afterwards.
- Same stream with in_valid randomly low 50% of cycles:
  - Identical write contents and addresses; exactly 128 wr_en pulses; done exactly once.
- in_last asserted on pixel #500 and absent on #1023:
  - err_last=1 from the cycle after pixel #500; the tile still completes at 128 words.
  - A following start clears err_last to 0.
- rst_n dropped after pixel #13:
  - All outputs 0 asynchronously; no write for the partial word 1.
  - After a new start, pixels 0..7 are written to addr 0.
- start held high continuously with a full stream:
  - Busy gaps are exactly 1 cycle between tiles (done cycle = IDLE).
  - The second tile writes begin at addr 0.
  - start pulses during FILL have no effect.
- in_valid=1 while in IDLE with no start:
  - in_ready=0, no pixels accepted, wr_en stays 0.

Source files
------------

// File: rtl/tile_dma_packer.sv
// tile_dma_packer
//   Upstream feeder for the tile buffer bank. It accepts a one-pixel-per-clock
//   DMA stream through a valid/ready handshake and packs PIX_PER_CLK pixels
//   into each buffer word. Words go to the buffer write port at sequential
//   addresses. Each start command transfers exactly one TILE_W x TILE_H tile.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin one tile transfer (honoured only while idle)
//   busy      out  high while filling a tile
//   done      out  one-cycle pulse, coincident with the final word write
//   err_last  out  sticky framing error (in_last misplaced) for current/last tile
//   in_valid  in   pixel valid
//   in_ready  out  packer can accept a pixel
//   in_data   in   pixel value
//   in_last   in   marks the final pixel of the tile
//   wr_en     out  buffer write strobe
//   wr_addr   out  buffer word address
//   wr_data   out  packed word, lane 0 in the LSBs
module tile_dma_packer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TILE_W      = 32,
    parameter int unsigned TILE_H      = 32,
    parameter int unsigned PIX_PER_CLK = 8,
    localparam int unsigned WORDS  = TILE_W * TILE_H / PIX_PER_CLK,
    localparam int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned LANE_W = (PIX_PER_CLK > 1) ? $clog2(PIX_PER_CLK) : 1,
    localparam int unsigned WORD_W = DATA_W * PIX_PER_CLK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data
);

    localparam logic [LANE_W-1:0] LastLane = LANE_W'(PIX_PER_CLK - 1);
    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(WORDS - 1);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic accept;
    logic last_lane;
    logic final_pix;

    assign accept    = in_valid && (state_q == StFill);
    assign last_lane = (lane_q == LastLane);
    assign final_pix = last_lane && (word_q == LastWord);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        word_d    = word_q;
        pack_d    = pack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    lane_d  = '0;
                    word_d  = '0;
                    err_d   = 1'b0;
                end
            end
            StFill: begin
                if (accept) begin
                    pack_d[lane_q*DATA_W +: DATA_W] = in_data;
                    // in_last must be set on the final pixel and nowhere else.
                    if (in_last != final_pix) begin
                        err_d = 1'b1;
                    end
                    if (last_lane) begin
                        lane_d    = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_q;
                        // pack_d already carries the pixel accepted this cycle.
                        wr_data_d = pack_d;
                        if (word_q == LastWord) begin
                            // Tile ends on pixel count regardless of in_last.
                            word_d  = '0;
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lane_q    <= '0;
            word_q    <= '0;
            pack_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            pack_q    <= pack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy     = (state_q == StFill);
    assign in_ready = (state_q == StFill);
    assign done     = done_q;
    assign err_last = err_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
